// File: rtl/dual_rail_value_capture.sv
// Clocked sink for a dual-rail link: synchronises each rail, waits for a complete word
// that is stable for two edges, presents it on valid/ready and returns the acknowledge.
module dual_rail_value_capture #(
    parameter     ENC         = "TP",
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0][1:0] in,
    output logic                  ack,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  err_o
);

    localparam bit TP_MODE = (ENC == "TP");
    // Out-of-range depths are clamped into the supported 2..4 window.
    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : ((SYNC_STAGES > 4) ? 4 : SYNC_STAGES);

    typedef enum logic [1:0] {
        WAIT_DATA   = 2'd0,
        OUT_VALID   = 2'd1,
        WAIT_SPACER = 2'd2
    } state_t;

    logic [WIDTH-1:0][1:0] r_sync [NSYNC];
    logic [WIDTH-1:0][1:0] w_s;
    logic [WIDTH-1:0][1:0] w_d;
    logic [WIDTH-1:0]      w_arrived;
    logic [WIDTH-1:0]      w_illegal;
    logic [WIDTH-1:0]      w_value;
    logic                  w_complete;
    logic                  w_spacer;

    state_t                r_state;
    state_t                w_state_next;
    logic [WIDTH-1:0][1:0] r_ref;
    logic [WIDTH-1:0][1:0] w_ref_next;
    logic [WIDTH-1:0]      r_cand;
    logic [WIDTH-1:0]      w_cand_next;
    logic                  r_cand_vld;
    logic                  w_cand_vld_next;
    logic [WIDTH-1:0]      r_data;
    logic [WIDTH-1:0]      w_data_next;
    logic                  r_valid;
    logic                  w_valid_next;
    logic                  r_ack;
    logic                  w_ack_next;
    logic                  r_err;
    logic                  w_err_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSYNC; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= in;
            for (int i = 1; i < NSYNC; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[NSYNC-1];

    // In TP a bit has arrived when exactly one rail moved away from the last acknowledged level.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_d[gi]       = TP_MODE ? (w_s[gi] ^ r_ref[gi]) : w_s[gi];
            assign w_arrived[gi] = w_d[gi][1] ^ w_d[gi][0];
            assign w_illegal[gi] = w_d[gi][1] & w_d[gi][0];
            assign w_value[gi]   = w_d[gi][1];
        end
    endgenerate

    assign w_complete = (&w_arrived) & ~(|w_illegal);
    assign w_spacer   = (w_s == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= WAIT_DATA;
            r_ref      <= '0;
            r_cand     <= '0;
            r_cand_vld <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ref      <= w_ref_next;
            r_cand     <= w_cand_next;
            r_cand_vld <= w_cand_vld_next;
            r_data     <= w_data_next;
            r_valid    <= w_valid_next;
            r_ack      <= w_ack_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ref_next      = r_ref;
        w_cand_next     = r_cand;
        w_cand_vld_next = r_cand_vld;
        w_data_next     = r_data;
        w_valid_next    = r_valid;
        w_ack_next      = r_ack;
        w_err_next      = r_err;

        case (r_state)
            WAIT_DATA: begin
                if (|w_illegal) begin
                    w_err_next = 1'b1;
                end
                // Skew filter: the same complete value must be seen on two consecutive edges.
                if (w_complete) begin
                    if (r_cand_vld && (r_cand == w_value)) begin
                        w_data_next     = w_value;
                        w_valid_next    = 1'b1;
                        w_cand_vld_next = 1'b0;
                        w_state_next    = OUT_VALID;
                    end else begin
                        w_cand_next     = w_value;
                        w_cand_vld_next = 1'b1;
                    end
                end else begin
                    w_cand_vld_next = 1'b0;
                end
            end

            OUT_VALID: begin
                if (ready_i) begin
                    w_valid_next = 1'b0;
                    if (TP_MODE) begin
                        w_ack_next   = ~r_ack;
                        w_ref_next   = w_s;
                        w_state_next = WAIT_DATA;
                    end else begin
                        w_ack_next   = 1'b1;
                        w_state_next = WAIT_SPACER;
                    end
                end
            end

            WAIT_SPACER: begin
                if (w_spacer) begin
                    w_ack_next   = 1'b0;
                    w_state_next = WAIT_DATA;
                end
            end

            default: begin
                w_state_next = WAIT_DATA;
            end
        endcase
    end

    assign ack     = r_ack;
    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign err_o   = r_err;

endmodule

// File: doc/dual_rail_value_capture.md
Name: dual_rail_value_capture

Overview:
Clocked sink stage on a dual-rail link, directly downstream of the value-inject point. It synchronises each rail into the clock domain and detects word completion. It decodes the word, presents it on a valid/ready interface and returns the link acknowledge, in either two-phase (TP) or four-phase return-to-zero encoding. This turns an asynchronous dual-rail channel into a synchronous data stream for checkers, scoreboards and the CPU-side bridge.

Parameters:
ENC, "TP", "TP" = two-phase transition signalling; any other value = four-phase RZ.
WIDTH, 1, number of dual-rail bits per word.
SYNC_STAGES, 2, flop stages per rail in the input synchroniser (legal range 2..4).

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-low.
in  input  [WIDTH-1:0][1:0]  dual-rail link; rail[1] = logic 1, rail[0] = logic 0.
ack  output  1  link acknowledge to upstream; a level in four-phase, a toggle in TP.
data_o  output  WIDTH  decoded word.
valid_o  output  1  data_o valid.
ready_i  input  1  consumer accepts data_o.
err_o  output  1  sticky protocol error.

Behaviour:
- Reset (rst low, asynchronous):
  - ack, data_o, valid_o and err_o go to 0.
  - Synchroniser flops and the TP reference register ref[WIDTH-1:0][1:0] go to 0.
  - FSM goes to WAIT_DATA.
- Synchroniser: every rail passes through SYNC_STAGES flops; the last stage is s[WIDTH-1:0][1:0].
- Bit arrival, per bit i:
  - TP: d = s[i] XOR ref[i]. Arrived when d is exactly one-hot. Value = d[1]. Illegal when d = 2'b11.
  - Four-phase: arrived when s[i] is exactly one-hot. Value = s[i][1]. Illegal when s[i] = 2'b11.
- Word complete: every bit has arrived and no bit is illegal.
- Spacer (four-phase only): all rails of s equal 0.
- FSM states:
  - WAIT_DATA:
    - The word must be complete on two consecutive clock edges with an identical decoded value. This is a skew filter.
    - On the second edge: data_o <= decoded value, valid_o <= 1, go to OUT_VALID.
    - If the value changes between the two edges, restart the filter.
  - OUT_VALID:
    - valid_o and data_o are held stable.
    - Changes on `in` are ignored; the upstream protocol forbids them before ack.
    - On ready_i = 1: valid_o <= 0 on the next edge.
    - TP: ack <= ~ack, ref <= s, go to WAIT_DATA.
    - Four-phase: ack <= 1, go to WAIT_SPACER.
  - WAIT_SPACER (four-phase only):
    - When spacer is seen: ack <= 0, go to WAIT_DATA.
    - Any non-spacer value is simply waited out.
- Latency:
  - Raw input edge to valid_o high: SYNC_STAGES+2 clocks, so 4 with defaults.
  - ready_i-qualified edge to ack change: same edge (ack is registered and updates together with valid_o falling).
  - Minimum spacing between back-to-back TP words: SYNC_STAGES+3 clocks.
- Backpressure: ready_i low holds OUT_VALID indefinitely; ack does not change.
- ready_i high while valid_o = 0 is ignored.
- Errors:
  - Any illegal bit seen in WAIT_DATA sets err_o, which is cleared only by reset.
  - While any bit is illegal the word is never complete; the FSM stays in WAIT_DATA.
  - The FSM recovers automatically if the rails later become legal.
- Partial words (some bits not yet arrived) never produce valid_o.
- Reset mid-operation:
  - All state clears immediately.
  - In TP, ack returning to 0 may look like a transition; upstream must be reset in the same window.
- WIDTH = 1 must work; data_o width tracks WIDTH with no padding.

Test Plan:
1. Four-phase, WIDTH=4: drive rails for 0xA (bits 3,1 on rail1; bits 2,0 on rail0), ready_i=1 -> valid_o high 4 clocks later with data_o=0xA, then ack=1. Drop all rails to 0 -> ack=0 within 3 clocks.
2. TP, WIDTH=4, ref=0: toggle rails for 0x5 -> data_o=0x5, ack 0->1. Toggle the same rails back for a second 0x5 -> data_o=0x5, ack 1->0. Then toggle for 0x3 -> data_o=0x3, ack 0->1.
3. Backpressure: complete a word with ready_i=0 for 10 clocks -> valid_o=1, data_o stable, ack unchanged. ready_i=1 for one clock -> valid_o=0 next clock and ack changes once.
4. Partial/skew: four-phase WIDTH=4, assert bits 0-2 at t0 and bit 3 at t0+5 -> valid_o stays 0 until SYNC_STAGES+2 clocks after bit 3. data_o = full value.
5. Error: four-phase, bit 0 both rails high, others valid -> err_o=1 and stays 1, valid_o=0. Clear bit 0 rail1 -> word captures with bit0=0 and err_o remains 1.
6. Reset in OUT_VALID with ack pending (four-phase, ack=1) -> asynchronous clear: valid_o, data_o, ack and err_o = 0 before the next clk edge. The FSM resumes from WAIT_DATA.
